icap_readback: RTL and testbench

- Reader counterpart to the standby ICAP reconfiguration sequencer.
- Drives ICAP_SPARTAN6 to read one 16-bit configuration register, e.g. BOOTSTS 0x20 (which image booted and whether fallback occurred), STAT 0x08 or GENERAL1-5.
- Performs sync, Type-1 read header, read-mode switch, capture, then desync.
- Sits between a CSR/host request port and the single ICAP primitive; owns the primitive exclusively.

---
 rtl/icap_readback.sv | 163 ++++++++++++++++
 tb/tb_icap_readback.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/icap_readback.sv
// Reads one 16-bit Spartan-6 configuration register through ICAP: sync, read header, capture, desync.
// Optional macro ICAP_TIMEOUT_EN bounds the READ wait to TIMEOUT cycles and reports error with done.
module icap_readback
`ifdef ICAP_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 255
)
`endif
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [5:0]  reg_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] data_out,
    output logic        icap_ce_n,
    output logic        icap_write_n,
    output logic [15:0] icap_i,
    input  logic [15:0] icap_o,
    input  logic        icap_busy
);

    typedef enum logic [4:0] {
        S_IDLE, S_DUMMY, S_SYNC1, S_SYNC2, S_NOP1, S_RDHDR, S_NOP2, S_NOP3,
        S_SW_R1, S_SW_R2, S_READ, S_SW_W1, S_SW_W2,
        S_DSY_C, S_DSY_D, S_NOP4, S_NOP5, S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        ce_n_q, ce_n_d;
    logic        write_n_q, write_n_d;
    logic [15:0] icap_i_q, word_d;
    logic [15:0] word_rev, icap_o_rev;
    logic        capture;
    logic        timeout_hit;

    // ICAP sees each byte MSB-first, so both directions are bit-reversed within bytes
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rev
            assign word_rev[gi]       = word_d[7-gi];
            assign word_rev[8+gi]     = word_d[15-gi];
            assign icap_o_rev[gi]     = icap_o[7-gi];
            assign icap_o_rev[8+gi]   = icap_o[15-gi];
        end
    endgenerate

    // ce_n_q low means the read strobe is already at the pins, so icap_busy is meaningful
    assign capture = (state_q == S_READ) && !ce_n_q && !icap_busy;

`ifdef ICAP_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          error_q, error_d;

    assign timeout_hit = (state_q == S_READ) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d   = '0;
        error_d = error_q;
        if (state_q == S_READ) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == S_IDLE && start) begin
            error_d = 1'b0;
        end else if (timeout_hit && !capture) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ce_n_d    = 1'b0;
        write_n_d = 1'b0;
        word_d    = 16'hFFFF;
        case (state_q)
            S_IDLE: begin
                ce_n_d = 1'b1;
                if (start) begin
                    addr_d  = reg_addr;
                    state_d = S_DUMMY;
                end
            end
            S_DUMMY: state_d = S_SYNC1;
            S_SYNC1: begin word_d = 16'hAA99; state_d = S_SYNC2; end
            S_SYNC2: begin word_d = 16'h5566; state_d = S_NOP1;  end
            S_NOP1:  begin word_d = 16'h2000; state_d = S_RDHDR; end
            S_RDHDR: begin
                word_d  = 16'h2801 | {5'b0, addr_q, 5'b0};
                state_d = S_NOP2;
            end
            S_NOP2:  begin word_d = 16'h2000; state_d = S_NOP3;  end
            S_NOP3:  begin word_d = 16'h2000; state_d = S_SW_R1; end
            S_SW_R1: begin ce_n_d = 1'b1; state_d = S_SW_R2; end
            S_SW_R2: begin ce_n_d = 1'b1; write_n_d = 1'b1; state_d = S_READ; end
            S_READ: begin
                write_n_d = 1'b1;
                if (capture) begin
                    data_d  = icap_o_rev;
                    state_d = S_SW_W1;
                end else if (timeout_hit) begin
                    state_d = S_SW_W1;
                end
            end
            S_SW_W1: begin ce_n_d = 1'b1; write_n_d = 1'b1; state_d = S_SW_W2; end
            S_SW_W2: begin ce_n_d = 1'b1; state_d = S_DSY_C; end
            S_DSY_C: begin word_d = 16'h30A1; state_d = S_DSY_D; end
            S_DSY_D: begin word_d = 16'h000D; state_d = S_NOP4;  end
            S_NOP4:  begin word_d = 16'h2000; state_d = S_NOP5;  end
            S_NOP5:  begin word_d = 16'h2000; state_d = S_FIN;   end
            S_FIN:   begin ce_n_d = 1'b1; state_d = S_IDLE; end
            default: begin ce_n_d = 1'b1; state_d = S_IDLE; end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            ce_n_q    <= 1'b1;
            write_n_q <= 1'b0;
            icap_i_q  <= 16'hFFFF;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ce_n_q    <= ce_n_d;
            write_n_q <= write_n_d;
            icap_i_q  <= word_rev;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FIN);
    assign data_out     = data_q;
    assign icap_ce_n    = ce_n_q;
    assign icap_write_n = write_n_q;
    assign icap_i       = icap_i_q;

endmodule

// File: tb/tb_icap_readback.sv
// Randomized bench for icap_readback with a behavioural ICAP model and expected-stream reference.
// Define ICAP_TIMEOUT_EN to also exercise the READ timeout path (TIMEOUT = 16).
module tb_icap_readback;

    localparam int TIMEOUT_TB = 16;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  reg_addr = '0;
    logic        busy, done, error;
    logic [15:0] data_out;
    logic        icap_ce_n, icap_write_n;
    logic [15:0] icap_i;
    logic [15:0] icap_o = '0;
    logic        icap_busy = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // ICAP model controls and observation state
    logic [15:0] m_val = '0;
    int          m_lat = 0;
    bit          m_stuck = 1'b0;
    int          rd_cnt = 0;
    logic [15:0] wq[$];
    int          done_cnt = 0;
    int          proto_err = 0;
    logic        prev_ce_n = 1'b1;
    logic        prev_wr = 1'b0;
    logic [15:0] last_data = '0;

    always #5 clk = ~clk;

`ifdef ICAP_TIMEOUT_EN
    icap_readback #(.TIMEOUT(TIMEOUT_TB)) dut (
`else
    icap_readback dut (
`endif
        .sys_clk(clk), .sys_rst_n(sys_rst_n), .start(start), .reg_addr(reg_addr),
        .busy(busy), .done(done), .error(error), .data_out(data_out),
        .icap_ce_n(icap_ce_n), .icap_write_n(icap_write_n), .icap_i(icap_i),
        .icap_o(icap_o), .icap_busy(icap_busy)
    );

    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]   = w[7-i];
            r[8+i] = w[15-i];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pin monitor and ICAP model: pins are stable at negedge, model answers before next posedge
    always @(negedge clk) begin
        logic bsy;
        if (icap_ce_n === 1'b0 && icap_write_n === 1'b0) wq.push_back(rev16(icap_i));
        if (prev_ce_n === 1'b0 && icap_ce_n === 1'b0 && icap_write_n !== prev_wr) proto_err++;
        prev_ce_n = icap_ce_n;
        prev_wr   = icap_write_n;
        if (done === 1'b1) done_cnt++;
        if (icap_ce_n === 1'b0 && icap_write_n === 1'b1) begin
            rd_cnt++;
            bsy       = m_stuck || (rd_cnt <= m_lat);
            icap_busy = bsy;
            icap_o    = bsy ? 16'($urandom) : rev16(m_val);
        end else begin
            rd_cnt    = 0;
            icap_busy = 1'b0;
            icap_o    = 16'($urandom);
        end
    end

    task automatic run_txn(input logic [5:0] addr, input logic [15:0] val, input int lat,
                           input bit stk, input bit dbl);
        int          cyc;
        bit          seen;
        logic        err_at_done;
        int          exp_r;
        logic [15:0] exp_hdr;
        logic [15:0] exp_data;
        logic [15:0] exp_w[11];
        logic [31:0] got_w;
        exp_hdr  = 16'h2801 | (16'(addr) << 5);
        exp_w    = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h2000, exp_hdr, 16'h2000, 16'h2000,
                     16'h30A1, 16'h000D, 16'h2000, 16'h2000};
        exp_r    = stk ? TIMEOUT_TB : lat + 2;
        exp_data = stk ? last_data : val;
        @(negedge clk);
        m_val = val; m_lat = lat; m_stuck = stk;
        wq.delete(); done_cnt = 0; proto_err = 0;
        reg_addr = addr;
        start = 1'b1;
        cyc = 0; seen = 1'b0; err_at_done = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start    = dbl && (cyc == 3);
            reg_addr = 6'($urandom);
            if (done === 1'b1) begin
                seen        = 1'b1;
                err_at_done = error;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", cyc, 16 + exp_r);
        check("error", 32'(err_at_done), 32'(stk));
        repeat (3) @(negedge clk);
        check("done_cnt", done_cnt, 1);
        check("busy_idle", 32'(busy), 32'd0);
        check("nwords", wq.size(), 11);
        for (int i = 0; i < 11; i++) begin
            got_w = (i < wq.size()) ? 32'(wq[i]) : 32'hDEADBEEF;
            check($sformatf("word%0d", i), got_w, 32'(exp_w[i]));
        end
        check("data", 32'(data_out), 32'(exp_data));
        check("proto", proto_err, 0);
        last_data = exp_data;
        m_stuck = 1'b0;
        $display("txn addr=%h val=%h lat=%0d stuck=%0d dbl=%0d cyc=%0d words=%0d data=%h err=%b",
                 addr, val, lat, stk, dbl, cyc, wq.size(), data_out, err_at_done);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ce_n", 32'(icap_ce_n), 32'd1);
        check("rst_write_n", 32'(icap_write_n), 32'd0);
        check("rst_icap_i", 32'(icap_i), 32'hFFFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        $display("reset ce_n=%b icap_i=%h busy=%b data=%h", icap_ce_n, icap_i, busy, data_out);
        sys_rst_n = 1'b1;

        run_txn(6'h20, 16'h0001, 2, 1'b0, 1'b0);
        run_txn(6'h08, 16'hA5C3, $urandom_range(0, 4), 1'b0, 1'b0);
        run_txn(6'($urandom), 16'($urandom), $urandom_range(0, 4), 1'b0, 1'b1);
`ifdef ICAP_TIMEOUT_EN
        run_txn(6'h20, 16'($urandom), 0, 1'b1, 1'b0);
        run_txn(6'($urandom), 16'($urandom), 1, 1'b0, 1'b0);
`endif

        // Reset asserted while the read strobe is at the pins
        @(negedge clk);
        m_stuck = 1'b1; m_lat = 0;
        reg_addr = 6'($urandom);
        start = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (icap_ce_n === 1'b0 && icap_write_n === 1'b1) seen = 1'b1;
        end
        check("rd_reached", 32'(seen), 32'd1);
        sys_rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ce_n", 32'(icap_ce_n), 32'd1);
        check("mid_rst_icap_i", 32'(icap_i), 32'hFFFF);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'd0);
        $display("midread reset ce_n=%b busy=%b data=%h", icap_ce_n, busy, data_out);
        sys_rst_n = 1'b1;
        m_stuck = 1'b0;
        last_data = '0;
        run_txn(6'h20, 16'($urandom), $urandom_range(0, 4), 1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            run_txn(6'($urandom), 16'($urandom), $urandom_range(0, 5), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
